// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus between the control unit and seq_divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;
  logic             overflow;

  // Control unit side: issues requests, observes results.
  modport master (
    output start, sign, a, b,
    input  busy, done, q, r, div_zero, overflow
  );

  // Divider side.
  modport slave (
    input  start, sign, a, b,
    output busy, done, q, r, div_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per cycle.
// Signed operands are divided as magnitudes and the signs are fixed up at the end.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int unsigned    CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_IT  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;     // partial remainder, one spare bit for the shifted value
  logic [WIDTH-1:0] r_dvd;     // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] r_dvs;     // divisor magnitude
  logic [WIDTH-1:0] r_a;       // original dividend, returned as remainder on divide-by-zero
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_div_zero;
  logic             r_overflow;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Operand magnitudes, trial subtraction and final sign fix-up.
  always_comb begin
    w_a_mag = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_b_mag = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    w_shift = {r_rem, r_dvd[WIDTH-1]};
    w_diff  = w_shift - {2'b00, r_dvs};
    w_ge    = ~w_diff[WIDTH+1];
    w_q_fix = r_neg_q ? -r_dvd : r_dvd;
    w_r_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  end

  // Control FSM and datapath. FIN spans two cycles: the first registers the
  // results, the second is the done cycle, during which start is still ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_a        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_div_zero <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_a     <= bus.a;
            r_neg_q <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r <= bus.sign & bus.a[WIDTH-1];
            r_zero  <= (bus.b == '0);
            r_ovf   <= bus.sign && (bus.a == MOST_NEG) && (bus.b == '1);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_IT) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          if (!r_done) begin
            r_q        <= r_zero ? '1  : w_q_fix;
            r_r        <= r_zero ? r_a : w_r_fix;
            r_div_zero <= r_zero;
            r_overflow <= r_ovf;
            r_done     <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.q        = r_q;
  assign bus.r        = r_r;
  assign bus.div_zero = r_div_zero;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, handshake corner cases,
// and random operands against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_divider_if #(.WIDTH(W)) bus();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic plus the two flagged special cases.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output logic ov);
    longint sa, sb;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; ov = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one request; returns edges from acceptance until done is seen.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.sign = s; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sign  = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic s, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                               input logic edz, input logic eov);
    int lat;
    do_op(s, a, b, lat);
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_q"}, bus.q, eq);
    chk({tag, "_r"}, bus.r, er);
    chk({tag, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, edz});
    chk({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, eov});
    chk({tag, "_busy_in_done"}, {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_q_held"}, bus.q, eq);
  endtask

  initial begin
    int pulses, dlat, lat;
    logic [31:0] qs, rs, mq, mr, ra, rb;
    logic mdz, mov, rsn;

    bus.start = 1'b0; bus.sign = 1'b0; bus.a = '0; bus.b = '0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'd123,        32'd0,          32'hFFFF_FFFF,  32'd123,        1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FF85,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF85,  1'b1, 1'b0};
    vecs[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_q", bus.q, 32'd0);
    chk("reset_r", bus.r, 32'd0);
    chk("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("reset_overflow", {31'd0, bus.overflow}, 32'd0);

    foreach (vecs[i])
      run_and_check($sformatf("vec%0d", i), vecs[i].sign, vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);

    // start pulsed mid-calculation is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    pulses = 0; dlat = 0; qs = '0; rs = '0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      bus.start = (i == 4);
      if (i == 4) begin bus.a = 32'd9; bus.b = 32'd3; end
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        if (pulses == 1) begin dlat = i; qs = bus.q; rs = bus.r; end
      end
    end
    chk("ignore_start_pulses", 32'(pulses), 32'd1);
    chk("ignore_start_latency", 32'(dlat), 32'd33);
    chk("ignore_start_q", qs, 32'd14);
    chk("ignore_start_r", rs, 32'd2);
    run_and_check("after_ignore", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

    // start held through the done cycle is taken only in the following idle cycle
    do_op(1'b0, 32'd100, 32'd7, lat);
    chk("done_cycle_latency", 32'(lat), 32'd33);
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd9; bus.b = 32'd3;
    @(posedge clk); #1;
    chk("done_cycle_start_ignored", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("idle_start_accepted", {31'd0, bus.busy}, 32'd1);
    chk("idle_start_q_held", bus.q, 32'd14);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("idle_start_latency", 32'(lat), 32'd33);
    chk("idle_start_q", bus.q, 32'd3);
    chk("idle_start_r", bus.r, 32'd0);
    @(posedge clk); #1;

    // reset mid-operation discards it
    @(negedge clk);
    bus.start = 1'b1; bus.sign = 1'b0; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_q", bus.q, 32'd0);
    chk("midrst_r", bus.r, 32'd0);
    chk("midrst_flags", {30'd0, bus.div_zero, bus.overflow}, 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);
    run_and_check("after_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);

    // random operands against the reference model
    for (int i = 0; i < 60; i++) begin
      rsn = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: begin ra = 32'h8000_0000; rb = $urandom; end
        4: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      model(rsn, ra, rb, mq, mr, mdz, mov);
      run_and_check($sformatf("rand%0d", i), rsn, ra, rb, mq, mr, mdz, mov);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle 32-bit integer divider for the datapath, the inverse of the combinational add/sub ALU. It produces quotient and remainder for signed or unsigned operands using a restoring shift-subtract algorithm, one quotient bit per cycle. A start/done handshake connects it to the control unit, which stalls on `busy`. Divide-by-zero and signed-overflow cases are flagged, not trapped.

## Interface
- `WIDTH`, 32: operand, quotient and remainder width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `sign`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `a`  in  WIDTH  dividend; sampled with `start`.
- `b`  in  WIDTH  divisor; sampled with `start`.
- `busy`  out  1  high from the cycle after start acceptance until done is asserted (inclusive of done cycle).
- `done`  out  1  one-cycle pulse; `q`/`r`/flags valid.
- `q`  out  WIDTH  quotient, held until next accepted start.
- `r`  out  WIDTH  remainder, held until next accepted start.
- `div_zero`  out  1  `b` was zero; held with `q`/`r`.
- `overflow`  out  1  signed `a` = most-negative, `b` = -1; held with `q`/`r`.

## Operation
- States: IDLE, CALC, FIN.
- IDLE: if `start`=1, latch `sign`, `a`, `b`; compute magnitudes |a|, |b| (unsigned mode: raw values); record neg_q = sign & (a[MSB]^b[MSB]), neg_r = sign & a[MSB]; clear counter, partial remainder; go to CALC.
- CALC: each cycle shift {rem, dvd} left by 1; trial = rem - |b| (WIDTH+1 bits); if trial non-negative, rem = trial, quotient bit = 1, else 0. Counter increments; after WIDTH iterations go to FIN.
- FIN: apply sign fix-up (negate q if neg_q, negate r if neg_r), register `q`, `r`, flags, assert `done`=1 for this cycle only, return to IDLE.
- Results: truncating division; remainder takes the sign of the dividend; |r| < |b|.
- Divide by zero (b = 0, either mode): `q` = all ones, `r` = `a` (original value), `div_zero`=1. Same latency as normal operation.
- Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, `sign`=1): `q` = 0x80000000, `r` = 0, `overflow`=1, `div_zero`=0.
- Unsigned mode: `overflow` always 0.
- `start` while CALC or FIN: ignored, no effect on in-flight operation or outputs.
- `start` in the same cycle `done` is high: ignored (FSM is in FIN); accepted in the next IDLE cycle.
- Input changes after acceptance have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `q`=0, `r`=0, `div_zero`=0, `overflow`=0; state IDLE.
- `rst` mid-operation: next cycle all of the above, operation discarded, no `done` pulse.
- Start sampled at edge T: `busy`=1 from T; CALC occupies edges T+1..T+WIDTH; `done`=1 and new `q`/`r`/flags visible after edge T+WIDTH+1 (WIDTH+2 cycles of latency, 34 for WIDTH=32), fixed for all operand values.
- `busy` falls with the edge that ends the `done` cycle; back-to-back throughput one operation per WIDTH+3 cycles.
- `q`/`r`/flags change only on the FIN edge or reset.

## Test plan
- Unsigned 100 / 7, `sign`=0 -> after 34 cycles `done`=1, `q`=14, `r`=2, flags 0.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) -> `q`=0xFFFFFFFD, `r`=0xFFFFFFFF; signed 7 / -2 -> `q`=0xFFFFFFFD, `r`=1.
- Unsigned 0xFFFFFFFF / 1 -> `q`=0xFFFFFFFF, `r`=0; same operands signed -> `q`=0xFFFFFFFF, `r`=0.
- 0x80000000 / 0xFFFFFFFF signed -> `q`=0x80000000, `r`=0, `overflow`=1; 123 / 0 -> `q`=0xFFFFFFFF, `r`=123, `div_zero`=1.
- Start 100/7, pulse `start` with 9/3 at cycle 5 -> ignored; single `done`, `q`=14, `r`=2; 9/3 issued after IDLE -> `q`=3, `r`=0.
- Start 100/7, assert `rst` at cycle 10 -> next cycle all outputs 0, no `done`; new request afterwards completes in 34 cycles.
